// File: rtl/chacha_qr_seq.sv
// ChaCha quarter-round sequencer on two independent 32-bit lanes, one lane op per cycle.
// Optional CHACHA_QR_ITER_EN adds in_iter for 1..16 chained passes.
//
// state | meaning
// IDLE  | waiting for in_valid, in_ready high
// RUN   | one schedule step per cycle, r_step = current step
// DONE  | result presented on out_*, waiting for out_ready
module chacha_qr_seq (
  input  logic        g_clk,
  input  logic        g_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  input  logic [63:0] in_c,
  input  logic [63:0] in_d,
`ifdef CHACHA_QR_ITER_EN
  input  logic [3:0]  in_iter,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_a,
  output logic [63:0] out_b,
  output logic [63:0] out_c,
  output logic [63:0] out_d,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t      r_state;
  logic [63:0] r_a, r_b, r_c, r_d;
  logic [2:0]  r_step;
`ifdef CHACHA_QR_ITER_EN
  logic [3:0]  r_pass;
`endif

  logic [63:0] w_x, w_y, w_xor, w_res;
  logic [4:0]  w_op_sel;  // {xr7, xr8, xr12, xr16, add}
  logic        w_last_pass;

  function automatic logic [31:0] f_add32(input logic [31:0] x, input logic [31:0] y);
    return x + y;
  endfunction

  always_comb begin
    w_x = r_a;
    w_y = r_b;
    case (r_step[1:0])
      2'b00:   begin w_x = r_a; w_y = r_b; end
      2'b01:   begin w_x = r_d; w_y = r_a; end
      2'b10:   begin w_x = r_c; w_y = r_d; end
      default: begin w_x = r_b; w_y = r_c; end
    endcase
  end

  always_comb begin
    w_op_sel = 5'b00000;
    if (r_state == S_RUN) begin
      if (!r_step[0]) begin
        w_op_sel[0] = 1'b1;
      end else begin
        case (r_step[2:1])
          2'd0:    w_op_sel[1] = 1'b1;
          2'd1:    w_op_sel[2] = 1'b1;
          2'd2:    w_op_sel[3] = 1'b1;
          default: w_op_sel[4] = 1'b1;
        endcase
      end
    end
  end

  // Lanes are computed separately so no carry crosses bit 31/32.
  assign w_xor = w_x ^ w_y;

  always_comb begin
    w_res = 64'd0;
    case (1'b1)
      w_op_sel[0]: w_res = {f_add32(w_x[63:32], w_y[63:32]), f_add32(w_x[31:0], w_y[31:0])};
      w_op_sel[1]: w_res = {w_xor[47:32], w_xor[63:48], w_xor[15:0], w_xor[31:16]};
      w_op_sel[2]: w_res = {w_xor[51:32], w_xor[63:52], w_xor[19:0], w_xor[31:20]};
      w_op_sel[3]: w_res = {w_xor[55:32], w_xor[63:56], w_xor[23:0], w_xor[31:24]};
      w_op_sel[4]: w_res = {w_xor[56:32], w_xor[63:57], w_xor[24:0], w_xor[31:25]};
      default:     w_res = 64'd0;
    endcase
  end

`ifdef CHACHA_QR_ITER_EN
  assign w_last_pass = (r_pass == 4'd0);
`else
  assign w_last_pass = 1'b1;
`endif

  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      r_state   <= S_IDLE;
      r_a       <= 64'd0;
      r_b       <= 64'd0;
      r_c       <= 64'd0;
      r_d       <= 64'd0;
      r_step    <= 3'd0;
`ifdef CHACHA_QR_ITER_EN
      r_pass    <= 4'd0;
`endif
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= in_a;
            r_b      <= in_b;
            r_c      <= in_c;
            r_d      <= in_d;
            r_step   <= 3'd0;
`ifdef CHACHA_QR_ITER_EN
            r_pass   <= in_iter;
`endif
            in_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          case (r_step[1:0])
            2'b00:   r_a <= w_res;
            2'b01:   r_d <= w_res;
            2'b10:   r_c <= w_res;
            default: r_b <= w_res;
          endcase
          r_step <= r_step + 3'd1;
          if (r_step == 3'd7) begin
            if (w_last_pass) begin
              out_valid <= 1'b1;
              r_state   <= S_DONE;
            end
`ifdef CHACHA_QR_ITER_EN
            else begin
              r_pass <= r_pass - 4'd1;
            end
`endif
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_a = r_a;
  assign out_b = r_b;
  assign out_c = r_c;
  assign out_d = r_d;

endmodule

// File: tb/tb_chacha_qr_seq.sv
// Self-checking bench for chacha_qr_seq: vector table, random vs reference model, corner sequences.
module tb_chacha_qr_seq;

  logic        g_clk = 1'b0;
  logic        g_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
  logic [3:0]  in_iter = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_a, out_b, out_c, out_d;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 g_clk = ~g_clk;

  chacha_qr_seq dut (
    .g_clk     (g_clk),
    .g_rst     (g_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .in_d      (in_d),
`ifdef CHACHA_QR_ITER_EN
    .in_iter   (in_iter),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .busy      (busy)
  );

  typedef struct {
    logic [63:0] a, b, c, d;
    logic [63:0] ea, eb, ec, ed;
  } vec_t;

  vec_t tbl[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Textbook quarter-round on one 32-bit lane.
  function automatic logic [127:0] qr(input logic [127:0] s);
    logic [31:0] a, b, c, d;
    {a, b, c, d} = s;
    a = a + b; d = rol(d ^ a, 16);
    c = c + d; b = rol(b ^ c, 12);
    a = a + b; d = rol(d ^ a, 8);
    c = c + d; b = rol(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  task automatic model(input logic [63:0] a, b, c, d, input int passes,
                       output logic [63:0] ra, rb, rc, rd);
    logic [127:0] hi, lo;
    hi = {a[63:32], b[63:32], c[63:32], d[63:32]};
    lo = {a[31:0], b[31:0], c[31:0], d[31:0]};
    for (int p = 0; p < passes; p++) begin
      hi = qr(hi);
      lo = qr(lo);
    end
    ra = {hi[127:96], lo[127:96]};
    rb = {hi[95:64], lo[95:64]};
    rc = {hi[63:32], lo[63:32]};
    rd = {hi[31:0], lo[31:0]};
  endtask

  function automatic logic [4:0] exp_sel(input int step);
    case (step % 8)
      1: return 5'b00010;
      3: return 5'b00100;
      5: return 5'b01000;
      7: return 5'b10000;
      default: return 5'b00001;
    endcase
  endfunction

  task automatic wait_ready(input string name);
    int k = 0;
    while (!in_ready && k < 200) begin
      @(negedge g_clk);
      k++;
    end
    if (!in_ready) begin
      n_chk++; n_err++;
      $display("FAIL %s_ready_timeout actual=0 required=1", name);
    end
  endtask

  // Accept at E0, then verify per-cycle selects, latency, result and handshake.
  task automatic run_txn(input string name, input logic [63:0] a, b, c, d, input logic [3:0] it,
                         input logic [63:0] ea, eb, ec, ed, input bit bp);
    int passes, lat;
    bit seen;
`ifdef CHACHA_QR_ITER_EN
    passes = int'(it) + 1;
`else
    passes = 1;
`endif
    wait_ready(name);
    out_ready = !bp;
    in_a = a; in_b = b; in_c = c; in_d = d; in_iter = it;
    in_valid = 1'b1;
    @(posedge g_clk);
    lat = 0;
    seen = 0;
    for (int j = 0; j < 200; j++) begin
      @(negedge g_clk);
      if (j == 0) begin
        in_valid = 1'b1;  // held high while busy: must be ignored
        in_a = $urandom; in_b = $urandom; in_c = $urandom; in_d = $urandom;
      end
      if (out_valid) begin
        lat = j; seen = 1;
        break;
      end
      if (j < 8) begin
        check({name, "_sel"}, {59'd0, dut.w_op_sel}, {59'd0, exp_sel(j)});
        check({name, "_ready_run"}, {63'd0, in_ready}, 64'd0);
      end
    end
    in_valid = 1'b0;
    if (!seen) begin
      n_chk++; n_err++;
      $display("FAIL %s_done_timeout actual=0 required=1", name);
      return;
    end
    check({name, "_latency"}, lat, 8 * passes);
    check({name, "_a"}, out_a, ea);
    check({name, "_b"}, out_b, eb);
    check({name, "_c"}, out_c, ec);
    check({name, "_d"}, out_d, ed);
    check({name, "_sel_done"}, {59'd0, dut.w_op_sel}, 64'd0);
    if (bp) begin
      for (int k = 0; k < 5; k++) begin
        in_valid = ~in_valid;
        in_a = $urandom; in_b = $urandom;
        @(negedge g_clk);
        check({name, "_bp_valid"}, {63'd0, out_valid}, 64'd1);
        check({name, "_bp_ready"}, {63'd0, in_ready}, 64'd0);
        check({name, "_bp_a"}, out_a, ea);
        check({name, "_bp_d"}, out_d, ed);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge g_clk);
    check({name, "_ready_after"}, {63'd0, in_ready}, 64'd1);
    check({name, "_valid_after"}, {63'd0, out_valid}, 64'd0);
    check({name, "_busy_after"}, {63'd0, busy}, 64'd0);
    check({name, "_sel_idle"}, {59'd0, dut.w_op_sel}, 64'd0);
  endtask

  initial begin
    logic [63:0] ra, rb, rc, rd, va, vb, vc, vd;
    logic [3:0]  it;
    int          passes;

    tbl[0] = '{64'h11111111_00000000, 64'h01020304_00000000, 64'h9b8d6f43_00000000,
               64'h01234567_00000000, 64'hea2a92f4_00000000, 64'hcb1cf8ce_00000000,
               64'h4581472e_00000000, 64'h5881c4bb_00000000};
    tbl[1] = '{64'h11111111_11111111, 64'h01020304_01020304, 64'h9b8d6f43_9b8d6f43,
               64'h01234567_01234567, 64'hea2a92f4_ea2a92f4, 64'hcb1cf8ce_cb1cf8ce,
               64'h4581472e_4581472e, 64'h5881c4bb_5881c4bb};
    tbl[2] = '{64'h00000000_11111111, 64'h00000000_01020304, 64'h00000000_9b8d6f43,
               64'h00000000_01234567, 64'h00000000_ea2a92f4, 64'h00000000_cb1cf8ce,
               64'h00000000_4581472e, 64'h00000000_5881c4bb};

    repeat (3) @(negedge g_clk);
    g_rst = 1'b0;
    @(negedge g_clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_out_a", out_a, 64'd0);
    check("rst_out_d", out_d, 64'd0);

    for (int i = 0; i < 3; i++)
      run_txn($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, 4'd0,
              tbl[i].ea, tbl[i].eb, tbl[i].ec, tbl[i].ed, 1'b0);

    run_txn("bp", tbl[0].a, tbl[0].b, tbl[0].c, tbl[0].d, 4'd0,
            tbl[0].ea, tbl[0].eb, tbl[0].ec, tbl[0].ed, 1'b1);

    // Abort mid-RUN at step s3, then a clean run must not see residue.
    wait_ready("abort");
    in_a = $urandom; in_b = $urandom; in_c = $urandom; in_d = $urandom;
    in_valid = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    in_valid = 1'b0;
    repeat (3) @(negedge g_clk);
    check("abort_step3_sel", {59'd0, dut.w_op_sel}, 64'b00100);
    g_rst = 1'b1;
    #1;
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_out_b", out_b, 64'd0);
    @(negedge g_clk);
    g_rst = 1'b0;
    @(negedge g_clk);
    check("abort_no_result", {63'd0, out_valid}, 64'd0);
    run_txn("post_abort", tbl[0].a, tbl[0].b, tbl[0].c, tbl[0].d, 4'd0,
            tbl[0].ea, tbl[0].eb, tbl[0].ec, tbl[0].ed, 1'b0);

    for (int i = 0; i < 12; i++) begin
      va = {$urandom, $urandom}; vb = {$urandom, $urandom};
      vc = {$urandom, $urandom}; vd = {$urandom, $urandom};
`ifdef CHACHA_QR_ITER_EN
      it = 4'($urandom_range(0, 3));
      passes = int'(it) + 1;
`else
      it = 4'($urandom_range(0, 15));
      passes = 1;
`endif
      model(va, vb, vc, vd, passes, ra, rb, rc, rd);
      run_txn($sformatf("rnd%0d", i), va, vb, vc, vd, it, ra, rb, rc, rd, 1'b0);
    end

`ifdef CHACHA_QR_ITER_EN
    model(tbl[0].a, tbl[0].b, tbl[0].c, tbl[0].d, 2, ra, rb, rc, rd);
    run_txn("iter1", tbl[0].a, tbl[0].b, tbl[0].c, tbl[0].d, 4'd1, ra, rb, rc, rd, 1'b0);
    va = {$urandom, $urandom}; vb = {$urandom, $urandom};
    vc = {$urandom, $urandom}; vd = {$urandom, $urandom};
    model(va, vb, vc, vd, 16, ra, rb, rc, rd);
    run_txn("iter15", va, vb, vc, vd, 4'd15, ra, rb, rc, rd, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/chacha_qr_seq.md
# chacha_qr_seq

Multi-cycle sequencer that runs one ChaCha quarter-round on two independent 32-bit lanes packed in 64-bit words, issuing one packed add or one packed xor-rotate per cycle to a shared 2x32 lane unit. It sits beside the ChaCha ISE datapath as the micro-sequenced alternative: software or a round engine loads a, b, c and d once, and the block returns the updated state after a fixed latency under valid/ready handshakes.

## Interface
- Parameters: none.
- g_clk  in  1  clock, all state updates on rising edge.
- g_rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input words valid.
- in_ready  out  1  block accepts input; high only in IDLE.
- in_a, in_b, in_c, in_d  in  64 each  packed state: bits [63:32] are the hi lane, bits [31:0] are the lo lane.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- out_a, out_b, out_c, out_d  out  64 each  result; driven directly from the working registers.
- busy  out  1  high in RUN or DONE.
- in_iter  in  4  iteration count; present only with CHACHA_QR_ITER_EN.

## Operation
- Working registers: A, B, C and D, each 64 bits. Step counter s is 3 bits.
- Lane unit, per 32-bit lane with no carry between lanes:
  - add: x+y mod 2^32.
  - xorrol n: rotate-left(x^y, n), with n taken from {16, 12, 8, 7}.
- Step schedule, one step per RUN cycle:
  - s0: A=A+B
  - s1: D=rol(D^A,16)
  - s2: C=C+D
  - s3: B=rol(B^C,12)
  - s4: A=A+B
  - s5: D=rol(D^A,8)
  - s6: C=C+D
  - s7: B=rol(B^C,7)
- Exactly one op select is active per RUN cycle. No op select is active outside RUN.
- FSM states and transitions:
  - IDLE: in_valid & in_ready loads A..D from the inputs, clears s, and goes to RUN.
  - RUN: s increments each cycle. After s7 the block goes to DONE; with iterations remaining it instead wraps s to 0 and stays in RUN.
  - DONE: out_valid=1. out_valid & out_ready goes to IDLE.
- in_valid outside IDLE is ignored and does not stall or corrupt the operation.
- out_* are held stable while out_valid=1 and out_ready=0.
- Reset values:
  - State is IDLE, A..D=0 and s=0.
  - in_ready=1, out_valid=0, busy=0, out_*=0.
- g_rst asserted mid-RUN or in DONE aborts immediately. The pending result is discarded and not presented after reset.

## Timing
- Accept edge E0: in_valid=1 and in_ready=1 sampled.
- Steps s0..s7 update at edges E1..E8. out_valid rises after E8, giving an 8-cycle latency from acceptance to out_valid.
- in_ready is low from after E0 until the edge that completes the output handshake, then high the following cycle. Back-to-back minimum issue interval is 10 cycles when out_ready is held high.
- out_ready held high on entry to DONE: out_valid is high for exactly one cycle.
- No combinational path from in_valid to out_valid, or from out_ready to in_ready.

## Configuration
- CHACHA_QR_ITER_EN defined:
  - in_iter is sampled at acceptance.
  - The 8-step schedule is executed in_iter+1 times back-to-back, for 1 to 16 passes.
  - Latency is 8*(in_iter+1) cycles.
  - An internal 4-bit pass counter decrements at each s7; RUN goes to DONE at s7 when the counter is 0.
- CHACHA_QR_ITER_EN undefined: the in_iter port is absent and exactly one pass is performed, with 8-cycle latency.

## Test plan
- RFC 7539 §2.1.1 vector in the hi lane with the lo lane all zero:
  - Stimulus: in_a=0x11111111_00000000, in_b=0x01020304_00000000, in_c=0x9b8d6f43_00000000, in_d=0x01234567_00000000.
  - Required: out_a=0xea2a92f4_00000000, out_b=0xcb1cf8ce_00000000, out_c=0x4581472e_00000000, out_d=0x5881c4bb_00000000, with out_valid rising 8 cycles after acceptance.
- Same vector placed in both lanes: the same result appears in both halves, proving lane independence and no carry across bit 31/32.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Outputs must stay stable, in_ready must stay 0, and a toggling in_valid must be ignored. Release out_ready: in_ready=1 on the next cycle.
- Reset mid-RUN: assert g_rst at step s3.
  - Required: in_ready=1, out_valid=0 and busy=0 immediately.
  - A new accept then produces the correct RFC result with no residue from the aborted run.
- Per-cycle op-select checks:
  - Order add, xr16, add, xr12, add, xr8, add, xr7.
  - Exactly one select active per RUN cycle.
  - No select active in IDLE or DONE.
- With CHACHA_QR_ITER_EN:
  - in_iter=1 on the RFC vector gives the result of two chained quarter-rounds, checked against a software model.
  - Latency is 16 cycles.
  - in_iter=15 gives latency 128 cycles.
